alu_writeback_stage: RTL and testbench



---
 rtl/proc_pkg.sv | 22 ++
 rtl/alu.sv | 42 ++++
 rtl/alu_writeback_stage.sv | 54 +++++
 tb/tb_alu_writeback_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants: datapath widths and ALU operation encodings.
// Imported by the execute/write-back stage and the ALU control decoder.
package proc_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR   = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_NOR   = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SLT   = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLTU  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SLL   = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRL   = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_SRA   = 4'b1010;
    localparam logic [CTRL_W-1:0] ALU_PASSB = 4'b1011;

endpackage

// File: rtl/alu.sv
// 32-bit ALU: arithmetic, logic, compare and shift operations with carry flag.
// Latency: combinational. Backpressure: none.
import proc_pkg::*;

module alu (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CTRL_W-1:0] control,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [4:0]      shamt;

    // Subtraction as A + ~B + 1 so the carry out is directly the no-borrow flag.
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (control)
            ALU_ADD:   begin result = sum[DATA_W-1:0];  cout = sum[DATA_W];  end
            ALU_SUB:   begin result = diff[DATA_W-1:0]; cout = diff[DATA_W]; end
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOR:   result = ~(a | b);
            ALU_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_PASSB: result = b;
            default:   ;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute/write-back slice: ALU plus AR/T register and data selects, registered write port.
// Latency: ALU combinational, write port 1 cycle. Backpressure: none, one instruction per cycle.
import proc_pkg::*;

module alu_writeback_stage (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [CTRL_W-1:0] alu_control,
    input  logic [REG_W-1:0]  rd_ar,
    input  logic [REG_W-1:0]  rd_t,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic              sel_reg,
    input  logic              sel_data,
    input  logic              reg_write_in,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_cout,
    output logic              alu_zero,
    output logic [REG_W-1:0]  write_reg_q,
    output logic [DATA_W-1:0] write_data_q,
    output logic              reg_write_q
);

    logic [REG_W-1:0]  write_reg_next;
    logic [DATA_W-1:0] write_data_next;

    alu u_alu (
        .a       (alu_a),
        .b       (alu_b),
        .control (alu_control),
        .result  (alu_result),
        .cout    (alu_cout)
    );

    assign alu_zero = (alu_result == '0);

    // AND-OR form of a 2:1 mux so an unknown select propagates instead of merging.
    assign write_reg_next  = ({REG_W{sel_reg}}   & rd_t)    | ({REG_W{~sel_reg}}   & rd_ar);
    assign write_data_next = ({DATA_W{sel_data}} & imm_ext) | ({DATA_W{~sel_data}} & alu_result);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            write_reg_q  <= write_reg_next;
            write_data_q <= write_data_next;
            reg_write_q  <= reg_write_in;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: expected write ports queued at drive, popped after the edge.
module tb_alu_writeback_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] alu_a, alu_b, imm_ext;
    logic [3:0]  alu_control, rd_ar, rd_t;
    logic        sel_reg, sel_data, reg_write_in;
    logic [31:0] alu_result, write_data_q;
    logic        alu_cout, alu_zero, reg_write_q;
    logic [3:0]  write_reg_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  wreg;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    exp_t sb[$];

    alu_writeback_stage dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .rd_ar        (rd_ar),
        .rd_t         (rd_t),
        .imm_ext      (imm_ext),
        .sel_reg      (sel_reg),
        .sel_data     (sel_data),
        .reg_write_in (reg_write_in),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_zero     (alu_zero),
        .write_reg_q  (write_reg_q),
        .write_data_q (write_data_q),
        .reg_write_q  (reg_write_q)
    );

    always #5 CLK = ~CLK;

    // Reference ALU written independently from the RTL structure.
    task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                           output logic [31:0] r, output logic c);
        logic [63:0] ext;
        logic [32:0] s;
        r = 32'h0;
        c = 1'b0;
        case (ctl)
            4'd0:  begin s = 33'(a) + 33'(b); r = s[31:0]; c = s[32]; end
            4'd1:  begin r = a - b; c = (a >= b); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a & ~b;
            4'd6:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: begin ext = {{32{a[31]}}, a} >> b[4:0]; r = ext[31:0]; end
            4'd11: r = b;
            default: ;
        endcase
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                         input logic [3:0] ar, input logic [3:0] t, input logic [31:0] imm,
                         input logic sr, input logic sd, input logic we, input logic push);
        exp_t e;
        logic [31:0] r;
        logic c;
        @(negedge CLK);
        alu_a = a; alu_b = b; alu_control = ctl;
        rd_ar = ar; rd_t = t; imm_ext = imm;
        sel_reg = sr; sel_data = sd; reg_write_in = we;
        ref_alu(a, b, ctl, r, c);
        e.wreg  = sr ? t : ar;
        e.wdata = sd ? imm : r;
        e.we    = we;
        if (push) sb.push_back(e);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(32'h1234_5678, 32'h1, 4'd0, 4'd5, 4'd6, 32'hAAAA_AAAA, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge CLK); #1;
        checks++; if (write_reg_q !== 4'h0)   begin errors++; $display("FAIL reset_wreg got %h exp 0", write_reg_q); end
        checks++; if (write_data_q !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", write_data_q); end
        checks++; if (reg_write_q !== 1'b0)   begin errors++; $display("FAIL reset_we got %b exp 0", reg_write_q); end
        checks++; if (alu_result !== 32'h1234_5679) begin errors++; $display("FAIL reset_alu_live got %h exp 12345679", alu_result); end
        RESET = 1'b0;
    endtask

    task automatic test_add();
        exp_t e;
        drive(32'hFFFF_FFFF, 32'h1, 4'd0, 4'd1, 4'd2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL add_res got %h exp 0", alu_result); end
        checks++; if (alu_cout !== 1'b1)    begin errors++; $display("FAIL add_cout got %b exp 1", alu_cout); end
        checks++; if (alu_zero !== 1'b1)    begin errors++; $display("FAIL add_zero got %b exp 1", alu_zero); end
        @(posedge CLK); #1;
        e = sb.pop_front();
        checks++; if (write_data_q !== e.wdata || write_reg_q !== 4'd1) begin errors++; $display("FAIL add_wb got %h/%h exp %h/1", write_data_q, write_reg_q, e.wdata); end
    endtask

    task automatic test_sub_slt();
        drive(32'd5, 32'd7, 4'd1, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (alu_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_res got %h exp fffffffe", alu_result); end
        checks++; if (alu_cout !== 1'b0)            begin errors++; $display("FAIL sub_cout got %b exp 0", alu_cout); end
        checks++; if (alu_zero !== 1'b0)            begin errors++; $display("FAIL sub_zero got %b exp 0", alu_zero); end
        alu_control = 4'd6; #1;
        checks++; if (alu_result !== 32'd1) begin errors++; $display("FAIL slt_res got %h exp 1", alu_result); end
        checks++; if (alu_cout !== 1'b0)    begin errors++; $display("FAIL slt_cout got %b exp 0", alu_cout); end
        alu_a = 32'hFFFF_FFFF; alu_b = 32'd1; alu_control = 4'd7; #1;
        checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL sltu_res got %h exp 0", alu_result); end
        alu_control = 4'd6; #1;
        checks++; if (alu_result !== 32'd1) begin errors++; $display("FAIL slt_neg_res got %h exp 1", alu_result); end
        alu_a = 32'd7; alu_b = 32'd7; alu_control = 4'd1; #1;
        checks++; if (alu_result !== 32'd0 || alu_cout !== 1'b1) begin errors++; $display("FAIL sub_eq got %h/%b exp 0/1", alu_result, alu_cout); end
        @(posedge CLK); #1;
    endtask

    task automatic test_shifts();
        drive(32'h8000_0000, 32'h21, 4'd10, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (alu_result !== 32'hC000_0000) begin errors++; $display("FAIL sra_res got %h exp c0000000", alu_result); end
        alu_control = 4'd9; #1;
        checks++; if (alu_result !== 32'h4000_0000) begin errors++; $display("FAIL srl_res got %h exp 40000000", alu_result); end
        alu_control = 4'd8; #1;
        checks++; if (alu_result !== 32'h0 || alu_zero !== 1'b1) begin errors++; $display("FAIL sll_res got %h/%b exp 0/1", alu_result, alu_zero); end
        alu_control = 4'd12; alu_a = 32'hFFFF_FFFF; alu_b = 32'h1; #1;
        checks++; if (alu_result !== 32'h0 || alu_cout !== 1'b0) begin errors++; $display("FAIL undef_op got %h/%b exp 0/0", alu_result, alu_cout); end
        @(posedge CLK); #1;
    endtask

    task automatic test_ar_writeback();
        exp_t e;
        drive(32'd2, 32'd3, 4'd0, 4'd3, 4'd9, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge CLK); #1;
        e = sb.pop_front();
        checks++; if (write_reg_q !== 4'd3 || e.wreg !== 4'd3)     begin errors++; $display("FAIL ar_wreg got %h exp 3", write_reg_q); end
        checks++; if (write_data_q !== 32'd5 || e.wdata !== 32'd5) begin errors++; $display("FAIL ar_wdata got %h exp 5", write_data_q); end
        checks++; if (reg_write_q !== 1'b1)                        begin errors++; $display("FAIL ar_we got %b exp 1", reg_write_q); end
    endtask

    task automatic test_t_writeback();
        exp_t e;
        drive(32'd2, 32'd3, 4'd0, 4'd3, 4'd9, 32'hFFFF_FFF6, 1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge CLK); #1;
        e = sb.pop_front();
        checks++; if (write_reg_q !== e.wreg)   begin errors++; $display("FAIL t_wreg got %h exp %h", write_reg_q, e.wreg); end
        checks++; if (write_data_q !== e.wdata) begin errors++; $display("FAIL t_wdata got %h exp %h", write_data_q, e.wdata); end
        checks++; if (write_data_q !== 32'hFFFF_FFF6 || write_reg_q !== 4'd9) begin errors++; $display("FAIL t_const got %h/%h exp fffffff6/9", write_data_q, write_reg_q); end
        drive(32'd4, 32'd4, 4'd1, 4'd7, 4'd2, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge CLK); #1;
        e = sb.pop_front();
        checks++; if (write_reg_q !== 4'd7 || write_data_q !== 32'h11 || reg_write_q !== 1'b0) begin errors++; $display("FAIL we_low got %h/%h/%b exp 7/11/0", write_reg_q, write_data_q, reg_write_q); end
        checks++; if (e.we !== reg_write_q) begin errors++; $display("FAIL we_low_sb got %b exp %b", reg_write_q, e.we); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        RESET = 1'b1;
        drive(32'd10, 32'd20, 4'd0, 4'd4, 4'd8, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge CLK); #1;
        checks++; if (write_reg_q !== 4'h0 || write_data_q !== 32'h0 || reg_write_q !== 1'b0) begin errors++; $display("FAIL mid_reset got %h/%h/%b exp 0/0/0", write_reg_q, write_data_q, reg_write_q); end
        checks++; if (alu_result !== 32'd30) begin errors++; $display("FAIL mid_reset_alu got %h exp 1e", alu_result); end
        RESET = 1'b0;
        drive(32'd10, 32'd20, 4'd0, 4'd4, 4'd8, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (reg_write_q !== 1'b0) begin errors++; $display("FAIL post_reset_we got %b exp 0", reg_write_q); end
        @(posedge CLK); #1;
        e = sb.pop_front();
        checks++; if (write_reg_q !== e.wreg || write_data_q !== e.wdata || reg_write_q !== e.we) begin errors++; $display("FAIL resume got %h/%h/%b exp %h/%h/%b", write_reg_q, write_data_q, reg_write_q, e.wreg, e.wdata, e.we); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] a, b, r;
        logic [3:0]  ctl;
        logic        c;
        for (int i = 0; i < 60; i++) begin
            a   = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            b   = (i % 5 == 0) ? a : $urandom;
            ctl = 4'($urandom_range(0, 15));
            drive(a, b, ctl, 4'($urandom), 4'($urandom), $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            #1;
            ref_alu(a, b, ctl, r, c);
            checks++; if (alu_result !== r || alu_cout !== c || alu_zero !== (r == 32'h0)) begin errors++; $display("FAIL b2b_alu op %0d got %h/%b/%b exp %h/%b", ctl, alu_result, alu_cout, alu_zero, r, c); end
            @(posedge CLK); #1;
            e = sb.pop_front();
            checks++; if (write_reg_q !== e.wreg || write_data_q !== e.wdata || reg_write_q !== e.we) begin errors++; $display("FAIL b2b_wb got %h/%h/%b exp %h/%h/%b", write_reg_q, write_data_q, reg_write_q, e.wreg, e.wdata, e.we); end
        end
    endtask

    initial begin
        RESET = 1'b1;
        alu_a = '0; alu_b = '0; alu_control = '0; rd_ar = '0; rd_t = '0;
        imm_ext = '0; sel_reg = 1'b0; sel_data = 1'b0; reg_write_in = 1'b0;
        test_reset();
        test_add();
        test_sub_slt();
        test_shifts();
        test_ar_writeback();
        test_t_writeback();
        test_reset_mid();
        test_back_to_back();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
